// File: rtl/ahb_sram_bist_master.sv
// AHB-Lite BIST master: fills an SRAM window with a pattern, reads it back and
// reports pass/fail, a saturating error count and the first failing word.
module ahb_sram_bist_master #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 15,
    parameter int ERR_W  = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [31:0]       first_err_data,
    output logic              hsel,
    output logic [31:0]       haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [31:0]       hwdata,
    input  logic              hready,
    input  logic [1:0]        hresp,
    input  logic [31:0]       hrdata
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, addr_q, dp_addr;
    logic [CNT_W-1:0]  num_q, beat_cnt;
    logic [1:0]        mode_q;
    logic              first_beat;
    logic              dp_any, dp_rd;
    logic [31:0]       dp_exp;
    logic              abort_q, pass_q;
    logic [31:0]       addr_ext, pattern;
    logic              issue, last_beat, abort, mismatch;

    assign addr_ext  = {{(32-ADDR_W){1'b0}}, addr_q};
    assign issue     = (state == S_WR || state == S_RD) && hready;
    assign last_beat = (beat_cnt == num_q - CNT_W'(1));
    assign abort     = dp_any && (hresp != 2'b00);
    // Only a completed read data phase is compared; an error response takes priority.
    assign mismatch  = dp_rd && hready && !abort && (hrdata != dp_exp);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pattern = addr_ext;
        case (mode_q)
            2'd1:    pattern = beat_cnt[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            2'd2:    pattern = ~addr_ext;
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!hresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_words == '0) ? S_DONE : S_WR;
            S_WR:    if (abort) state_nxt = S_DONE;
                     else if (issue && last_beat) state_nxt = S_RD;
            S_RD:    if (abort) state_nxt = S_DONE;
                     else if (issue && last_beat) state_nxt = S_DRAIN;
            S_DRAIN: if (abort || hready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        pass   = pass_q;
        hsel   = 1'b0;
        haddr  = '0;
        htrans = TR_IDLE;
        hwrite = 1'b0;
        hburst = 3'b000;
        case (state)
            S_WR, S_RD: begin
                busy   = 1'b1;
                hsel   = 1'b1;
                haddr  = addr_ext;
                // A new burst and every 1 KB crossing restart as NONSEQ.
                htrans = (first_beat || addr_q[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                hwrite = (state == S_WR);
                hburst = 3'b001;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = (err_cnt == '0) && !abort_q;
            end
            default: ;
        endcase
    end

    assign hsize = 3'b010;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            base_q         <= '0;
            addr_q         <= '0;
            num_q          <= '0;
            mode_q         <= '0;
            beat_cnt       <= '0;
            first_beat     <= 1'b0;
            dp_any         <= 1'b0;
            dp_rd          <= 1'b0;
            dp_addr        <= '0;
            dp_exp         <= '0;
            hwdata         <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            abort_q        <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                base_q         <= base_addr & ~ADDR_W'(3);
                addr_q         <= base_addr & ~ADDR_W'(3);
                num_q          <= num_words;
                mode_q         <= (mode == 2'd3) ? 2'd0 : mode;
                beat_cnt       <= '0;
                first_beat     <= 1'b1;
                err_cnt        <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                abort_q        <= 1'b0;
                pass_q         <= 1'b0;
            end
            if (issue) begin
                addr_q     <= addr_q + ADDR_W'(4);
                beat_cnt   <= beat_cnt + CNT_W'(1);
                first_beat <= 1'b0;
                dp_addr    <= addr_q;
                dp_exp     <= pattern;
                if (state == S_WR) hwdata <= pattern;
                // Rewind to the base for the read pass straight after the last write.
                if (state == S_WR && last_beat) begin
                    addr_q     <= base_q;
                    beat_cnt   <= '0;
                    first_beat <= 1'b1;
                end
            end
            if (abort) begin
                dp_any <= 1'b0;
                dp_rd  <= 1'b0;
            end else if (hready) begin
                dp_any <= issue;
                dp_rd  <= issue && (state == S_RD);
            end
            if ((abort || mismatch) && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (mismatch && err_cnt == '0) begin
                first_err_addr <= dp_addr;
                first_err_data <= hrdata;
            end
            if (abort) abort_q <= 1'b1;
            if (state == S_DONE) pass_q <= (err_cnt == '0) && !abort_q;
        end
    end

endmodule

// File: tb/tb_ahb_sram_bist_master.sv
// Scoreboard bench for ahb_sram_bist_master: a small AHB slave model feeds the DUT,
// monitors pop expected beats, write data and end-of-test results as the DUT produces them.
module tb_ahb_sram_bist_master;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tr;
        logic        wr;
    } beat_t;

    typedef struct {
        int          lat;
        logic        pass;
        logic [15:0] ec;
        logic [15:0] fa;
        logic [31:0] fd;
    } res_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [14:0] num_words = '0;
    logic [1:0]  mode = '0;
    logic        busy, done, pass;
    logic [15:0] err_cnt, first_err_addr;
    logic [31:0] first_err_data;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic        hready = 1'b1;
    logic [1:0]  hresp = 2'b00;
    logic [31:0] hrdata = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int stall_from = 0;
    int stall_len = 0;
    int stuck_addr = -1;
    int err_addr = -1;

    beat_t       exp_beat[$];
    logic [31:0] exp_wd[$];
    res_t        exp_res[$];
    logic [31:0] mem [int];

    logic        sl_dp_valid = 1'b0;
    logic        sl_dp_write = 1'b0;
    logic [15:0] sl_dp_addr = '0;
    logic        p_stall = 1'b0;
    logic        p_hsel = 1'b0;
    logic [31:0] p_haddr = '0;
    logic [31:0] p_hwdata = '0;
    logic [1:0]  p_htrans = '0;

    ahb_sram_bist_master dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .mode           (mode),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .hsel           (hsel),
        .haddr          (haddr),
        .htrans         (htrans),
        .hwrite         (hwrite),
        .hsize          (hsize),
        .hburst         (hburst),
        .hwdata         (hwdata),
        .hready         (hready),
        .hresp          (hresp),
        .hrdata         (hrdata)
    );

    always #5 hclk = ~hclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] pat(input logic [15:0] a, input int i, input logic [1:0] md);
        case (md)
            2'd1:    return (i % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
            2'd2:    return ~{16'h0, a};
            default: return {16'h0, a};
        endcase
    endfunction

    // Slave data-phase driver: read data, wait states and error responses.
    always @(posedge hclk) begin
        logic [31:0] rd;
        cyc++;
        #1;
        hready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
        hrdata = 32'h0;
        if (sl_dp_valid && !sl_dp_write) begin
            rd = mem.exists(int'(sl_dp_addr)) ? mem[int'(sl_dp_addr)] : 32'hDEAD_BEEF;
            if (int'(sl_dp_addr) == stuck_addr) rd = rd | 32'h0000_0008;
            hrdata = rd;
        end
        hresp = (sl_dp_valid && int'(sl_dp_addr) == err_addr) ? 2'b01 : 2'b00;
    end

    // Slave address sampler plus scoreboard monitors, all away from the active edge.
    always @(negedge hclk) begin
        beat_t b;
        res_t  r;
        if (!hresetn) begin
            sl_dp_valid = 1'b0;
            p_stall     = 1'b0;
        end else begin
            if (p_stall && p_hsel)
                check("stall_frozen", 64'({haddr, htrans, hwdata}), 64'({p_haddr, p_htrans, p_hwdata}));
            if (hready) begin
                if (sl_dp_valid && sl_dp_write) begin
                    mem[int'(sl_dp_addr)] = hwdata;
                    if (exp_wd.size() == 0) flag("hwdata_unexpected");
                    else check("hwdata", 64'(hwdata), 64'(exp_wd.pop_front()));
                end
                sl_dp_valid = hsel && htrans[1];
                sl_dp_write = hwrite;
                sl_dp_addr  = haddr[15:0];
                if (sl_dp_valid) begin
                    if (exp_beat.size() == 0) flag("beat_unexpected");
                    else begin
                        b = exp_beat.pop_front();
                        check("beat", 64'({haddr, htrans, hwrite, hburst, hsize}),
                              64'({b.addr, b.tr, b.wr, 3'b001, 3'b010}));
                    end
                end
            end
            if (done) begin
                if (exp_res.size() == 0) flag("done_unexpected");
                else begin
                    r = exp_res.pop_front();
                    check("done_latency", 64'(cyc - start_cyc), 64'(r.lat));
                    check("pass", 64'(pass), 64'(r.pass));
                    check("err_cnt", 64'(err_cnt), 64'(r.ec));
                    check("first_err_addr", 64'(first_err_addr), 64'(r.fa));
                    check("first_err_data", 64'(first_err_data), 64'(r.fd));
                end
            end
            p_stall  = !hready;
            p_hsel   = hsel;
            p_haddr  = haddr;
            p_htrans = htrans;
            p_hwdata = hwdata;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, pass, hsel, hwrite, htrans, hburst}), 64'd0);
        check({tag, "_err"}, 64'({err_cnt, first_err_addr}), 64'd0);
        check({tag, "_errdata"}, 64'(first_err_data), 64'd0);
        check({tag, "_haddr"}, 64'(haddr), 64'd0);
        check({tag, "_hwdata"}, 64'(hwdata), 64'd0);
    endtask

    task automatic push_expect(input logic [15:0] base, input logic [1:0] md, input int nw, input int nr);
        beat_t       b;
        logic [15:0] a;
        int          i;
        for (int k = 0; k < nw + nr; k++) begin
            i    = (k < nw) ? k : k - nw;
            a    = (base & 16'hFFFC) + 16'(4 * i);
            b.addr = {16'h0, a};
            b.tr   = (i == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
            b.wr   = (k < nw);
            exp_beat.push_back(b);
            if (k < nw) exp_wd.push_back(pat(a, i, md));
        end
    endtask

    task automatic launch(input logic [15:0] base, input logic [14:0] n, input logic [1:0] md);
        @(posedge hclk);
        #1;
        base_addr = base;
        num_words = n;
        mode      = md;
        start     = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_test(input logic [15:0] base, input logic [14:0] n, input logic [1:0] md,
                            input int nw, input int nr, input int lat, input logic ep,
                            input logic [15:0] ec, input logic [15:0] fa, input logic [31:0] fd,
                            input int stall_at, input int poke_at);
        res_t r;
        push_expect(base, md, nw, nr);
        r.lat = lat; r.pass = ep; r.ec = ec; r.fa = fa; r.fd = fd;
        exp_res.push_back(r);
        launch(base, n, md);
        if (stall_at >= 0) begin
            stall_from = start_cyc + stall_at;
            stall_len  = 3;
        end
        for (int t = 1; t <= 400 && exp_res.size() != 0; t++) begin
            @(posedge hclk);
            #1;
            start = (t == poke_at);
            if (t == poke_at) begin
                base_addr = 16'h0100;
                num_words = 15'd2;
            end
            if (t == 1) check("busy_c1", 64'(busy), 64'(n != 15'd0));
        end
        if (exp_res.size() != 0) begin
            flag("done_timeout");
            exp_res.delete();
        end
        @(posedge hclk);
        #1;
        check("beats_left", 64'(exp_beat.size() + exp_wd.size()), 64'd0);
        check("pass_hold", 64'(pass), 64'(ep));
        exp_beat.delete();
        exp_wd.delete();
        stall_len  = 0;
        stuck_addr = -1;
        err_addr   = -1;
    endtask

    initial begin
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        check_idle("reset");
        hresetn = 1'b1;
        repeat (2) @(posedge hclk);

        // Address pattern, clean memory: done at cycle 2N+2.
        run_test(16'h0000, 15'd4, 2'd0, 4, 4, 10, 1'b1, 16'd0, 16'd0, 32'd0, -1, 0);
        // Zero-length test: immediate done, no bus traffic.
        run_test(16'h0040, 15'd0, 2'd0, 0, 0, 1, 1'b1, 16'd0, 16'd0, 32'd0, -1, 0);
        // Stuck bit 3 at 0x10 with checkerboard, plus a start pulse while busy.
        stuck_addr = 32'h10;
        run_test(16'h0000, 15'd8, 2'd1, 8, 8, 18, 1'b0, 16'd1, 16'h0010, 32'h5555_555D, -1, 3);
        // 1 KB boundary crossing; low address bits ignored; inverted address pattern.
        run_test(16'h03FB, 15'd4, 2'd2, 4, 4, 10, 1'b1, 16'd0, 16'd0, 32'd0, -1, 0);
        // Wrap at the top of the window; reserved mode behaves as address pattern.
        run_test(16'hFFF8, 15'd4, 2'd3, 4, 4, 10, 1'b1, 16'd0, 16'd0, 32'd0, -1, 0);
        // Three wait states mid-write delay done by exactly three cycles.
        run_test(16'h0200, 15'd8, 2'd1, 8, 8, 21, 1'b1, 16'd0, 16'd0, 32'd0, 3, 0);
        // Error response on the third write data phase aborts early.
        err_addr = 32'h8;
        run_test(16'h0000, 15'd8, 2'd0, 4, 0, 5, 1'b0, 16'd1, 16'd0, 32'd0, -1, 0);

        // Reset at cycle 5 of a 16-word test: outputs clear at once, no done pulse.
        push_expect(16'h0000, 2'd0, 16, 16);
        launch(16'h0000, 15'd16, 2'd0);
        for (int t = 1; t <= 5; t++) begin
            @(posedge hclk);
            #1;
            start = 1'b0;
        end
        check("mid_busy_before_rst", 64'(busy), 64'd1);
        hresetn = 1'b0;
        #1;
        check_idle("mid_rst");
        exp_beat.delete();
        exp_wd.delete();
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        repeat (40) @(posedge hclk);
        run_test(16'h0000, 15'd4, 2'd0, 4, 4, 10, 1'b1, 16'd0, 16'd0, 32'd0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
